// File: rtl/i2c_reg_bank.sv
// Register bank serving the i2c_slave reg_* handshake: ID, RO inputs, RW outputs.
// Define I2C_REG_BANK_EVENT_EN to add W1C event flags (0x01) with enable mask (0x02) and irq.
module i2c_reg_bank #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [7:0]  ID_VALUE   = 8'hA5,
  parameter int          NUM_RO     = 4,
  parameter int          NUM_RW     = 12,
  parameter int unsigned RO_BASE    = 32'h10,
  parameter int unsigned RW_BASE    = 32'h20,
  parameter logic [7:0]  RW_RESET   = 8'h00,
  parameter int          NUM_EVT    = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] reg_address,
  input  logic                  reg_is_write,
  input  logic                  reg_request,
  input  logic [7:0]            reg_write_data,
  output logic                  reg_response,
  output logic [7:0]            reg_read_data,
  input  logic [NUM_RO*8-1:0]   ro_in,
  output logic [NUM_RW*8-1:0]   rw_out,
  output logic [NUM_RW-1:0]     rw_wstrobe,
  input  logic [NUM_EVT-1:0]    event_in,
  output logic                  irq,
  output logic                  access_error
);

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    WAIT
  } state_t;

  state_t state_q, state_d;
  logic   exec;
  logic   wr_exec;
  logic   mapped;
  logic [7:0]        rd_data;
  logic [NUM_RW-1:0] rw_hit;
  logic [31:0]       addr_w;
  logic [7:0]        rw_q [NUM_RW];

`ifdef I2C_REG_BANK_EVENT_EN
  logic               stat_hit;
  logic               en_hit;
  logic [NUM_EVT-1:0] evt_status;
  logic [NUM_EVT-1:0] evt_enable;
  logic [NUM_EVT-1:0] evt_prev;
  logic [NUM_EVT-1:0] evt_clr;
`endif

  assign addr_w       = 32'(reg_address);
  assign reg_response = (state_q == RESP);
  assign wr_exec      = exec & reg_is_write;

  always_comb begin
    state_d = state_q;
    exec    = 1'b0;
    unique case (state_q)
      IDLE: if (reg_request) begin
        exec    = 1'b1;
        state_d = RESP;
      end
      RESP: state_d = WAIT;
      WAIT: if (!reg_request) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Full address compared; at most one window can match.
  always_comb begin
    mapped  = 1'b0;
    rd_data = 8'h00;
    rw_hit  = '0;
`ifdef I2C_REG_BANK_EVENT_EN
    stat_hit = (addr_w == 32'd1);
    en_hit   = (addr_w == 32'd2);
    if (stat_hit) begin
      mapped  = 1'b1;
      rd_data = 8'(evt_status);
    end
    if (en_hit) begin
      mapped  = 1'b1;
      rd_data = 8'(evt_enable);
    end
`endif
    if (addr_w == 32'd0) begin
      mapped  = 1'b1;
      rd_data = ID_VALUE;
    end
    for (int i = 0; i < NUM_RO; i++) begin
      if (addr_w == RO_BASE + 32'(i)) begin
        mapped  = 1'b1;
        rd_data = ro_in[8*i +: 8];
      end
    end
    for (int i = 0; i < NUM_RW; i++) begin
      if (addr_w == RW_BASE + 32'(i)) begin
        mapped    = 1'b1;
        rw_hit[i] = 1'b1;
        rd_data   = rw_q[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      reg_read_data <= 8'h00;
      access_error  <= 1'b0;
      rw_wstrobe    <= '0;
      for (int i = 0; i < NUM_RW; i++) rw_q[i] <= RW_RESET;
    end else begin
      state_q      <= state_d;
      access_error <= exec & ~mapped;
      rw_wstrobe   <= wr_exec ? rw_hit : '0;
      if (exec && !reg_is_write) reg_read_data <= rd_data;
      for (int i = 0; i < NUM_RW; i++) begin
        if (wr_exec && rw_hit[i]) rw_q[i] <= reg_write_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_rw
    assign rw_out[8*g +: 8] = rw_q[g];
  end

`ifdef I2C_REG_BANK_EVENT_EN
  assign evt_clr = (wr_exec && stat_hit) ?
                   reg_write_data[NUM_EVT-1:0] : '0;

  // Set is ORed in after the clear so a same-cycle edge wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      evt_status <= '0;
      evt_enable <= '0;
      evt_prev   <= '1;
      irq        <= 1'b0;
    end else begin
      evt_prev   <= event_in;
      evt_status <= (evt_status & ~evt_clr) | (event_in & ~evt_prev);
      if (wr_exec && en_hit) evt_enable <= reg_write_data[NUM_EVT-1:0];
      irq <= |(evt_status & evt_enable);
    end
  end
`else
  logic unused_evt;
  assign unused_evt = ^event_in;
  assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Scoreboard bench for i2c_reg_bank.
// Build with I2C_REG_BANK_EVENT_EN to exercise the event flags.
module tb_i2c_reg_bank;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  reg_address;
  logic        reg_is_write;
  logic        reg_request;
  logic [7:0]  reg_write_data;
  logic        reg_response;
  logic [7:0]  reg_read_data;
  logic [31:0] ro_in;
  logic [95:0] rw_out;
  logic [11:0] rw_wstrobe;
  logic [7:0]  event_in;
  logic        irq;
  logic        access_error;

  i2c_reg_bank dut (
    .clock(clock), .reset(reset),
    .reg_address(reg_address), .reg_is_write(reg_is_write),
    .reg_request(reg_request), .reg_write_data(reg_write_data),
    .reg_response(reg_response), .reg_read_data(reg_read_data),
    .ro_in(ro_in), .rw_out(rw_out), .rw_wstrobe(rw_wstrobe),
    .event_in(event_in), .irq(irq), .access_error(access_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  d;
    logic        e;
    logic [11:0] s;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] rw_m [12];
  logic [7:0] last_rd = 8'h00;
  logic [7:0] st_m = 8'h00;
  logic [7:0] en_m = 8'h00;
  logic [7:0] ev_next = 8'h00;

  function automatic logic [95:0] rw_vec();
    logic [95:0] v;
    for (int i = 0; i < 12; i++) v[8*i +: 8] = rw_m[i];
    return v;
  endfunction

  // {error, read data} of the register map
  function automatic logic [8:0] model(input logic [7:0] a);
    if (a == 8'h00) return {1'b0, 8'hA5};
    if (a >= 8'h10 && a < 8'h14) return {1'b0, ro_in[8*(a-8'h10) +: 8]};
    if (a >= 8'h20 && a < 8'h2C) return {1'b0, rw_m[a-8'h20]};
`ifdef I2C_REG_BANK_EVENT_EN
    if (a == 8'h01) return {1'b0, st_m};
    if (a == 8'h02) return {1'b0, en_m};
`endif
    return {1'b1, 8'h00};
  endfunction

  task automatic access(input logic [7:0] a, input bit wr,
                        input logic [7:0] wd);
    exp_t        x;
    logic [8:0]  m;
    logic [11:0] one;
    int          lat;
    bit          seen;
    one = 12'd1;
    m   = model(a);
    x.e = m[8];
    x.d = wr ? last_rd : m[7:0];
    x.s = '0;
    if (wr && a >= 8'h20 && a < 8'h2C) x.s = one << (a - 8'h20);
    sb.push_back(x);
    @(negedge clock);
    reg_address    = a;
    reg_is_write   = wr;
    reg_write_data = wd;
    reg_request    = 1'b1;
    event_in       = ev_next;
    seen = 0;
    lat  = 0;
    while (!seen && lat < 4) begin
      @(negedge clock);
      lat++;
      if (reg_response === 1'b1) seen = 1;
    end
    x = sb.pop_front();
    checks++;
    if (!seen || lat != 1) begin
      errors++;
      $display("FAIL latency a=%h: got %0d cycles seen=%0d, want 1",
               a, lat, seen);
    end
    checks++;
    if (reg_read_data !== x.d) begin
      errors++;
      $display("FAIL read_data a=%h: got %h want %h", a, reg_read_data, x.d);
    end
    checks++;
    if (access_error !== x.e) begin
      errors++;
      $display("FAIL access_error a=%h: got %b want %b", a, access_error, x.e);
    end
    checks++;
    if (rw_wstrobe !== x.s) begin
      errors++;
      $display("FAIL wstrobe a=%h: got %h want %h", a, rw_wstrobe, x.s);
    end
    if (x.s != 0) rw_m[a-8'h20] = wd;
    if (!wr) last_rd = x.d;
    reg_request = 1'b0;
    @(negedge clock);
    checks++;
    if (reg_response !== 1'b0 || access_error !== 1'b0 ||
        rw_wstrobe !== 12'h000) begin
      errors++;
      $display("FAIL pulse_width a=%h: resp=%b err=%b strb=%h want 0/0/000",
               a, reg_response, access_error, rw_wstrobe);
    end
    checks++;
    if (rw_out !== rw_vec()) begin
      errors++;
      $display("FAIL rw_out a=%h: got %h want %h", a, rw_out, rw_vec());
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checks++;
    if (reg_response !== 1'b0 || access_error !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: resp=%b err=%b irq=%b want 0",
               reg_response, access_error, irq);
    end
    checks++;
    if (reg_read_data !== 8'h00 || rw_wstrobe !== 12'h000) begin
      errors++;
      $display("FAIL reset_data: rd=%h strb=%h want 00/000",
               reg_read_data, rw_wstrobe);
    end
    checks++;
    if (rw_out !== 96'h0) begin
      errors++;
      $display("FAIL reset_rw_out: got %h want 0", rw_out);
    end
  endtask

  task automatic test_id_rw_ro();
    access(8'h00, 0, 8'h00);
    access(8'h21, 1, 8'h5A);
    access(8'h21, 0, 8'h00);
    ro_in = 32'h003C_0000;
    access(8'h12, 0, 8'h00);
    access(8'h12, 1, 8'hFF);
    access(8'h12, 0, 8'h00);
    access(8'h00, 1, 8'h11);
    access(8'h00, 0, 8'h00);
  endtask

  task automatic test_unmapped();
    access(8'h7F, 0, 8'h00);
    access(8'h7F, 1, 8'hEE);
    access(8'h14, 0, 8'h00);
    access(8'h2C, 1, 8'h99);
    access(8'h1F, 0, 8'h00);
    access(8'hFF, 0, 8'h00);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) access(8'h20 + 8'(i), 1, 8'($urandom));
    for (int i = 11; i >= 0; i--) access(8'h20 + 8'(i), 0, 8'h00);
    ro_in = $urandom;
    for (int i = 0; i < 4; i++) access(8'h10 + 8'(i), 0, 8'h00);
  endtask

  task automatic test_hold();
    int n;
    n = 0;
    @(negedge clock);
    reg_address  = 8'h2B;
    reg_is_write = 1'b0;
    reg_request  = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (reg_response === 1'b1) n++;
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL hold_once: got %0d responses want 1", n);
    end
    checks++;
    if (reg_read_data !== rw_m[11]) begin
      errors++;
      $display("FAIL hold_data: got %h want %h", reg_read_data, rw_m[11]);
    end
    last_rd     = rw_m[11];
    reg_request = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    reg_address    = 8'h22;
    reg_is_write   = 1'b1;
    reg_write_data = 8'h77;
    reg_request    = 1'b1;
    @(negedge clock);
    checks++;
    if (reg_response !== 1'b1) begin
      errors++;
      $display("FAIL mid_resp: got %b want 1", reg_response);
    end
    reset        = 1'b1;
    reg_address  = 8'h00;
    reg_is_write = 1'b0;
    @(negedge clock);
    checks++;
    if (reg_response !== 1'b0 || rw_out !== 96'h0 || reg_read_data !== 8'h00 ||
        rw_wstrobe !== 12'h000 || access_error !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: resp=%b rw=%h rd=%h strb=%h err=%b want zeros",
               reg_response, rw_out, reg_read_data, rw_wstrobe, access_error);
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) rw_m[i] = 8'h00;
    st_m = 8'h00;
    en_m = 8'h00;
    @(negedge clock);
    checks++;
    if (reg_response !== 1'b1 || reg_read_data !== 8'hA5) begin
      errors++;
      $display("FAIL post_reset_req: resp=%b rd=%h want 1/a5",
               reg_response, reg_read_data);
    end
    last_rd     = 8'hA5;
    reg_request = 1'b0;
    repeat (2) @(negedge clock);
  endtask

`ifdef I2C_REG_BANK_EVENT_EN
  task automatic test_events();
    access(8'h02, 1, 8'h01);
    en_m = 8'h01;
    @(negedge clock);
    event_in = 8'h01;
    @(negedge clock);
    event_in = 8'h00;
    @(negedge clock);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL evt_irq_set: got %b want 1", irq);
    end
    st_m = 8'h01;
    access(8'h01, 0, 8'h00);
    access(8'h02, 0, 8'h00);
    ev_next = 8'h01;
    access(8'h01, 1, 8'h01);
    ev_next = 8'h00;
    access(8'h01, 0, 8'h00);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL evt_set_wins: irq got %b want 1", irq);
    end
    access(8'h01, 1, 8'h01);
    st_m = 8'h00;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL evt_w1c: irq got %b want 0", irq);
    end
    access(8'h01, 0, 8'h00);
  endtask
`else
  task automatic test_events();
    access(8'h01, 0, 8'h00);
    access(8'h02, 1, 8'hFF);
    access(8'h02, 0, 8'h00);
    @(negedge clock);
    event_in = 8'hFF;
    repeat (3) @(negedge clock);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_tied: got %b want 0", irq);
    end
    event_in = 8'h00;
  endtask
`endif

  initial begin
    reset          = 1'b1;
    reg_address    = 8'h00;
    reg_is_write   = 1'b0;
    reg_request    = 1'b0;
    reg_write_data = 8'h00;
    ro_in          = 32'h0;
    event_in       = 8'h00;
    for (int i = 0; i < 12; i++) rw_m[i] = 8'h00;
    test_reset();
    test_id_rw_ro();
    test_unmapped();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_events();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
